// File: rtl/mul_acc_iter_pkg.sv
// Shared types and sizing helpers for the iterative radix-4 multiply-accumulate unit.
package mul_acc_pkg;

   typedef enum logic {IDLE, RUN} mul_state_t;

   // One radix-4 digit is consumed per RUN cycle.
   function automatic int step_count(input int width);
      return width / 2;
   endfunction

   function automatic int count_bits(input int width);
      return $clog2(width / 2);
   endfunction

endpackage

// File: rtl/mul_acc_iter_radix4_step.sv
// One radix-4 multiply step: adds 0/1x/2x/3x of the multiplicand and pre-shifts it for the next digit.
module mul_radix4_step #(
   parameter int WIDTH = 64
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [2*WIDTH-1:0] mcand,
   input  logic [1:0]         digit,
   output logic [2*WIDTH-1:0] acc_next,
   output logic [2*WIDTH-1:0] mcand_next
);

   logic [2*WIDTH-1:0] mcand_x2;
   logic [2*WIDTH-1:0] partial;

   assign mcand_x2 = mcand << 1;

   always_comb begin
      partial = '0;
      unique case (digit)
         2'd0:    partial = '0;
         2'd1:    partial = mcand;
         2'd2:    partial = mcand_x2;
         default: partial = mcand_x2 + mcand;
      endcase
   end

   assign acc_next   = acc + partial;
   assign mcand_next = mcand << 2;

endmodule

// File: rtl/mul_acc_iter.sv
// Iterative radix-4 multiply-accumulate: product_out = A*B + C after a fixed WIDTH/2 cycles.
module mul_acc_iter
   import mul_acc_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [WIDTH-1:0]     multiplicand_in,
   input  logic [WIDTH-1:0]     multiplier_in,
   input  logic [WIDTH-1:0]     addend_in,
   input  logic                 data_valid_in,
   output logic [2*WIDTH-1:0]   product_out,
   output logic                 overflow_out,
   output logic                 data_valid_out,
   output logic                 busy_out
);

   localparam int STEPS = step_count(WIDTH);
   localparam int CW    = count_bits(WIDTH);

   if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("mul_acc_iter: WIDTH must be even and at least 4");
   end

   mul_state_t         state_reg, state_next;
   logic [2*WIDTH-1:0] acc_reg, acc_next;
   logic [2*WIDTH-1:0] mcand_reg, mcand_next;
   logic [WIDTH-1:0]   mplier_reg, mplier_next;
   logic [CW-1:0]      count_reg, count_next;
   logic [2*WIDTH-1:0] product_reg, product_next;
   logic               overflow_reg, overflow_next;
   logic               valid_reg, valid_next;

   logic [2*WIDTH-1:0] step_acc;
   logic [2*WIDTH-1:0] step_mcand;

   mul_radix4_step #(
      .WIDTH      (WIDTH)
   ) u_step (
      .acc        (acc_reg),
      .mcand      (mcand_reg),
      .digit      (mplier_reg[1:0]),
      .acc_next   (step_acc),
      .mcand_next (step_mcand)
   );

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         acc_reg      <= '0;
         mcand_reg    <= '0;
         mplier_reg   <= '0;
         count_reg    <= '0;
         product_reg  <= '0;
         overflow_reg <= 1'b0;
         valid_reg    <= 1'b0;
      end else begin
         acc_reg      <= acc_next;
         mcand_reg    <= mcand_next;
         mplier_reg   <= mplier_next;
         count_reg    <= count_next;
         product_reg  <= product_next;
         overflow_reg <= overflow_next;
         valid_reg    <= valid_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      acc_next      = acc_reg;
      mcand_next    = mcand_reg;
      mplier_next   = mplier_reg;
      count_next    = count_reg;
      product_next  = product_reg;
      overflow_next = overflow_reg;
      valid_next    = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (data_valid_in) begin
               acc_next    = {{WIDTH{1'b0}}, addend_in};
               mcand_next  = {{WIDTH{1'b0}}, multiplicand_in};
               mplier_next = multiplier_in;
               count_next  = CW'(STEPS - 1);
               state_next  = RUN;
            end
         end
         RUN: begin
            acc_next    = step_acc;
            mcand_next  = step_mcand;
            mplier_next = mplier_reg >> 2;
            count_next  = count_reg - CW'(1);
            // The last digit's contribution is folded in directly from the step output.
            if (count_reg == '0) begin
               product_next  = step_acc;
               overflow_next = |step_acc[2*WIDTH-1:WIDTH];
               valid_next    = 1'b1;
               state_next    = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign product_out    = product_reg;
   assign overflow_out   = overflow_reg;
   assign data_valid_out = valid_reg;
   assign busy_out       = (state_reg == RUN);

endmodule

// File: tb/tb_mul_acc_iter.sv
// Self-checking bench for mul_acc_iter: WIDTH=8 vectors and corner sequences, WIDTH=64 divider round trip.
module tb_mul_acc_iter;

   localparam int STEPS8  = 4;
   localparam int STEPS64 = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]   a8, b8, c8;
   logic         v8;
   logic [15:0]  p8;
   logic         ov8, dv8, busy8;

   logic [63:0]  a64, b64, c64;
   logic         v64;
   logic [127:0] p64;
   logic         ov64, dv64, busy64;

   mul_acc_iter #(.WIDTH(8)) dut8 (
      .clk_in          (clk),
      .rst_in          (rst_n),
      .multiplicand_in (a8),
      .multiplier_in   (b8),
      .addend_in       (c8),
      .data_valid_in   (v8),
      .product_out     (p8),
      .overflow_out    (ov8),
      .data_valid_out  (dv8),
      .busy_out        (busy8)
   );

   mul_acc_iter #(.WIDTH(64)) dut64 (
      .clk_in          (clk),
      .rst_in          (rst_n),
      .multiplicand_in (a64),
      .multiplier_in   (b64),
      .addend_in       (c64),
      .data_valid_in   (v64),
      .product_out     (p64),
      .overflow_out    (ov64),
      .data_valid_out  (dv64),
      .busy_out        (busy64)
   );

   typedef struct {
      logic [127:0] prod;
      logic         ov;
      int           acc_edge;
   } exp_t;

   typedef struct {
      logic [7:0]  a, b, c;
      logic [15:0] p;
      logic        ov;
   } vec_t;

   exp_t sb8[$];
   exp_t sb64[$];
   exp_t e8, e64;
   vec_t vecs[8];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Scoreboard pop on every completion pulse.
   always @(negedge clk) begin
      if (dv8) begin
         if (sb8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dv8_unexpected: got pulse p=%0d, required no pulse", p8);
         end else begin
            e8 = sb8.pop_front();
            $display("txn w8: product=%0d overflow=%0d latency=%0d", p8, ov8, cyc - e8.acc_edge);
            check("p8", 128'(p8), e8.prod);
            check("ov8", 128'(ov8), 128'(e8.ov));
            check("lat8", 128'(cyc - e8.acc_edge), 128'(STEPS8));
         end
      end
      if (dv64) begin
         if (sb64.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dv64_unexpected: got pulse p=0x%0h, required no pulse", p64);
         end else begin
            e64 = sb64.pop_front();
            $display("txn w64: product=0x%0h overflow=%0d", p64, ov64);
            check("p64", p64, e64.prod);
            check("ov64", 128'(ov64), 128'(e64.ov));
            check("lat64", 128'(cyc - e64.acc_edge), 128'(STEPS64));
         end
      end
   end

   // Drive at the current negedge; accepted on the next rising edge when idle.
   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input bit expect_acc, input logic [15:0] p, input logic ov);
      a8 = a; b8 = b; c8 = c; v8 = 1'b1;
      if (expect_acc) sb8.push_back('{prod: 128'(p), ov: ov, acc_edge: cyc + 1});
      @(negedge clk);
      v8 = 1'b0;
   endtask

   task automatic wait_drain(input int max);
      int n;
      n = 0;
      while ((sb8.size() != 0 || sb64.size() != 0) && n < max) begin
         @(negedge clk);
         n++;
      end
      if (sb8.size() != 0 || sb64.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d results outstanding, required 0", sb8.size() + sb64.size());
         sb8.delete();
         sb64.delete();
      end
   endtask

   initial begin
      logic [63:0] dividend, divisor, quo, rem;

      vecs[0] = '{a: 8'd13,  b: 8'd11,  c: 8'd5,   p: 16'd148,   ov: 1'b0};
      vecs[1] = '{a: 8'd255, b: 8'd255, c: 8'd255, p: 16'd65280, ov: 1'b1};
      vecs[2] = '{a: 8'd0,   b: 8'd200, c: 8'd7,   p: 16'd7,     ov: 1'b0};
      vecs[3] = '{a: 8'd1,   b: 8'd0,   c: 8'd0,   p: 16'd0,     ov: 1'b0};
      vecs[4] = '{a: 8'd255, b: 8'd1,   c: 8'd0,   p: 16'd255,   ov: 1'b0};
      vecs[5] = '{a: 8'd16,  b: 8'd16,  c: 8'd0,   p: 16'd256,   ov: 1'b1};
      vecs[6] = '{a: 8'd100, b: 8'd3,   c: 8'd200, p: 16'd500,   ov: 1'b1};
      vecs[7] = '{a: 8'd6,   b: 8'd7,   c: 8'd1,   p: 16'd43,    ov: 1'b0};

      a8 = '0; b8 = '0; c8 = '0; v8 = 1'b0;
      a64 = '0; b64 = '0; c64 = '0; v64 = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_product", 128'(p8), 128'(0));
      check("rst_overflow", 128'(ov8), 128'(0));
      check("rst_valid", 128'(dv8), 128'(0));
      check("rst_busy", 128'(busy8), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         issue8(vecs[i].a, vecs[i].b, vecs[i].c, 1'b1, vecs[i].p, vecs[i].ov);
         if (i == 0) begin
            check("busy_accept", 128'(busy8), 128'(1));
            for (int j = 1; j < 4; j++) begin
               @(negedge clk);
               check("busy_run", 128'(busy8), 128'(1));
            end
            @(negedge clk);
            check("busy_done", 128'(busy8), 128'(0));
            check("valid_done", 128'(dv8), 128'(1));
         end
         wait_drain(20);
      end

      // Request while busy is dropped; request in the pulse cycle is accepted.
      issue8(8'd3, 8'd3, 8'd0, 1'b1, 16'd9, 1'b0);
      @(negedge clk);
      a8 = 8'd9; b8 = 8'd3; c8 = 8'd0; v8 = 1'b1;
      @(negedge clk);
      v8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pulse_cycle_valid", 128'(dv8), 128'(1));
      issue8(8'd2, 8'd5, 8'd1, 1'b1, 16'd11, 1'b0);
      wait_drain(20);

      // Asynchronous reset during the second RUN cycle discards the operation.
      issue8(8'd7, 8'd7, 8'd0, 1'b0, 16'd0, 1'b0);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_product", 128'(p8), 128'(0));
      check("async_rst_overflow", 128'(ov8), 128'(0));
      check("async_rst_valid", 128'(dv8), 128'(0));
      check("async_rst_busy", 128'(busy8), 128'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      issue8(8'd6, 8'd7, 8'd1, 1'b1, 16'd43, 1'b0);
      wait_drain(20);

      // WIDTH=64: rebuild the dividend from a reference quotient/remainder.
      for (int n = 0; n < 1000; n++) begin
         dividend = {$urandom, $urandom};
         divisor  = {$urandom, $urandom} >> $urandom_range(63, 0);
         if (divisor == 64'd0) divisor = 64'd1;
         quo = dividend / divisor;
         rem = dividend % divisor;
         a64 = quo; b64 = divisor; c64 = rem; v64 = 1'b1;
         sb64.push_back('{prod: {64'd0, dividend}, ov: 1'b0, acc_edge: cyc + 1});
         @(negedge clk);
         v64 = 1'b0;
         wait_drain(50);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
